rr_sel_sched_v: RTL and testbench
=================================

# rr_sel_sched_v

Round-robin scheduler that sits directly upstream of the 4:1 8-bit mux and drives its select and enable. It arbitrates among four requesting 8-bit code sources and steers the winner through the mux. It captures the mux output into a register and presents it downstream with a valid/ready handshake. It also returns a one-cycle grant pulse to the source that was served.

## Interface
- `RST_PTR`, default 2'd3: last-served pointer value after reset. With the default, channel 0 has highest priority first.
- `i_clk`  in  1  sole clock; all state updates on its rising edge
- `i_rst`  in  1  synchronous, active-high reset
- `i_req`  in  4  per-channel request; bit k means `i_code_k` holds a code to send
- `i_code_0` … `i_code_3`  in  8 each  channel codes; source holds each stable while its request is high
- `i_ready`  in  1  downstream can accept `o_code` this cycle
- `o_sel_code`  out  2  select driven to the mux
- `o_en`  out  1  mux enable
- `o_code`  out  8  registered mux result
- `o_valid`  out  1  `o_code` is valid
- `o_grant`  out  4  one-hot pulse, one cycle, naming the channel whose code was captured

## Operation
- States:
  - IDLE: no transfer pending.
  - SEL: a winner is chosen; `o_sel_code` and `o_en` are driven to the mux.
  - HOLD: `o_code` is valid and waits for `i_ready`.
- Winner selection: the first set bit of `i_req` searching upward from `ptr+1`, modulo 4. `ptr` is the last-served channel.
  - Example: `ptr`=1 and `i_req`=4'b1011 gives winner 3.
- IDLE:
  - `o_en`=0.
  - If `i_req`≠0, register the winner into `o_sel_code` and go to SEL.
  - Otherwise stay in IDLE.
- SEL:
  - `o_en`=1.
  - Next edge:
    - `o_code` ← mux output
    - `o_valid` ← 1
    - `o_grant` ← onehot(`o_sel_code`) for exactly one cycle
    - `ptr` ← `o_sel_code`
    - go to HOLD
- HOLD:
  - `o_en`=0; `o_code` and `o_valid` are held.
  - When `i_ready`=1, the transfer completes.
    - If `i_req` is nonzero that cycle (the just-granted bit excluded from consideration), choose the next winner and go directly to SEL. `o_valid` drops to 0 for that one SEL cycle.
    - Otherwise go to IDLE and drop `o_valid`.
- A request that falls while in SEL is still captured; the source is granted anyway. Sources must not drop a request before they receive the grant.
- `o_code` changes only on the SEL→HOLD edge.

## Timing
- Reset (synchronous, takes priority over all other logic):
  - State = IDLE
  - `o_sel_code`=0, `o_en`=0, `o_code`=8'h00, `o_valid`=0, `o_grant`=0
  - `ptr`=`RST_PTR`
- Reset asserted in SEL or HOLD abandons the transfer. No grant is issued and the pending request is re-arbitrated after reset.
- Latency:
  - Request seen in IDLE at edge N → SEL during cycle N+1.
  - `o_valid`=1 and `o_grant` pulse after edge N+2.
- Throughput with back-to-back requests and `i_ready` held at 1: one code every 2 cycles (HOLD→SEL→HOLD).
- `o_grant` is high only in the first HOLD cycle, regardless of `i_ready`.
- `i_req` is sampled only in IDLE and in HOLD-with-`i_ready`. Changes at other times are ignored.

## Structure
- Shared package holds the state encoding constants:
  - `ST_IDLE`=2'd0
  - `ST_SEL`=2'd1
  - `ST_HOLD`=2'd2
- The package also holds the channel-count constant (4) and the code-width constant (8).
- One natural sub-module: the existing 4:1 8-bit mux `MUX_4_1_8_bit_v`. It is instantiated internally, fed from `o_sel_code` and `o_en`, and its output is the D input of `o_code`.
- The round-robin priority search is combinational logic in the top module; no separate file.

## Test plan
- Reset and single request:
  - Stimulus: assert `i_rst` for 2 cycles; then `i_req`=4'b0100, `i_code_2`=8'hA5, `i_ready`=1.
  - Response: `o_valid`=1 with `o_code`=8'hA5 two edges after the request; `o_grant`=4'b0100 for one cycle.
- Round-robin fairness:
  - Stimulus: all four requests held high, `i_ready`=1.
  - Response: grants in order 0,1,2,3,0 after reset; a new `o_valid` every 2 cycles.
- Backpressure:
  - Stimulus: `i_ready`=0 for 5 cycles in HOLD.
  - Response: `o_code` and `o_valid` held stable; no second grant; transfer completes on the cycle `i_ready` rises.
- Pointer wrap:
  - Stimulus: `ptr`=3, `i_req`=4'b1001.
  - Response: channel 0 is granted before channel 3.
- Mid-operation reset:
  - Stimulus: assert `i_rst` during SEL.
  - Response: no grant is issued; all outputs return to reset values on the next edge.
- Idle:
  - Stimulus: `i_req`=0 for 10 cycles.
  - Response: `o_en`=0, `o_valid`=0, `o_grant`=0 throughout.

Source files
------------

// File: rtl/rr_sel_sched_v_pkg.sv
// Shared constants and types for the round-robin mux scheduler.
// State encoding, channel count and code width live here.
package rr_sel_sched_v_pkg;

  localparam int NCH = 4;
  localparam int CW  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  function automatic logic [NCH-1:0] onehot(input logic [1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_sel_sched_v_mux.sv
// 4:1 8-bit mux with enable; output is zero when disabled.
// Select and enable come from the scheduler.
module MUX_4_1_8_bit_v
  import rr_sel_sched_v_pkg::*;
(
  input  logic [1:0]    i_sel,
  input  logic          i_en,
  input  logic [CW-1:0] i_d0,
  input  logic [CW-1:0] i_d1,
  input  logic [CW-1:0] i_d2,
  input  logic [CW-1:0] i_d3,
  output logic [CW-1:0] o_y
);

  always_comb begin
    o_y = '0;
    if (i_en) begin
      unique case (i_sel)
        2'd0: o_y = i_d0;
        2'd1: o_y = i_d1;
        2'd2: o_y = i_d2;
        2'd3: o_y = i_d3;
        default: o_y = '0;
      endcase
    end
  end

endmodule

// File: rtl/rr_sel_sched_v.sv
// Round-robin scheduler steering four code sources through a 4:1 mux,
// capturing the winner and handing it downstream with valid/ready.
module rr_sel_sched_v
  import rr_sel_sched_v_pkg::*;
#(
  parameter logic [1:0] RST_PTR = 2'd3
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [NCH-1:0] i_req,
  input  logic [CW-1:0]  i_code_0,
  input  logic [CW-1:0]  i_code_1,
  input  logic [CW-1:0]  i_code_2,
  input  logic [CW-1:0]  i_code_3,
  input  logic           i_ready,
  output logic [1:0]     o_sel_code,
  output logic           o_en,
  output logic [CW-1:0]  o_code,
  output logic           o_valid,
  output logic [NCH-1:0] o_grant
);

  state_e         state_q, state_d;
  logic [1:0]     sel_q, sel_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [CW-1:0]  code_q, code_d;
  logic           valid_q, valid_d;
  logic [NCH-1:0] grant_q, grant_d;
  logic [NCH-1:0] cand;
  logic [1:0]     win;
  logic [1:0]     idx;
  logic           hit;
  logic [CW-1:0]  mux_y;

  assign o_en = (state_q == ST_SEL);

  MUX_4_1_8_bit_v u_mux (
    .i_sel (sel_q),
    .i_en  (o_en),
    .i_d0  (i_code_0),
    .i_d1  (i_code_1),
    .i_d2  (i_code_2),
    .i_d3  (i_code_3),
    .o_y   (mux_y)
  );

  // In HOLD the channel just served is out of the running.
  always_comb begin
    cand = i_req;
    if (state_q == ST_HOLD)
      cand = i_req & ~onehot(ptr_q);
    win = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = ptr_q + 2'(i);
      if (!hit && cand[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    code_d  = code_q;
    valid_d = valid_q;
    grant_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (hit) begin
          sel_d   = win;
          state_d = ST_SEL;
        end
      end
      ST_SEL: begin
        code_d  = mux_y;
        valid_d = 1'b1;
        grant_d = onehot(sel_q);
        ptr_d   = sel_q;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (i_ready) begin
          valid_d = 1'b0;
          if (hit) begin
            sel_d   = win;
            state_d = ST_SEL;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= RST_PTR;
      code_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  assign o_sel_code = sel_q;
  assign o_code     = code_q;
  assign o_valid    = valid_q;
  assign o_grant    = grant_q;

endmodule

// File: tb/tb_rr_sel_sched_v.sv
// Scoreboard bench for rr_sel_sched_v: directed requests push expected
// grant/code pairs; a monitor checks them on each grant pulse.
module tb_rr_sel_sched_v;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [3:0] i_req;
  logic [7:0] i_code_0, i_code_1, i_code_2, i_code_3;
  logic       i_ready;
  logic [1:0] o_sel_code;
  logic       o_en;
  logic [7:0] o_code;
  logic       o_valid;
  logic [3:0] o_grant;

  typedef struct packed {
    logic [3:0] grant;
    logic [7:0] code;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;
  bit   done = 1'b0;

  always #5 i_clk = ~i_clk;

  rr_sel_sched_v dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_code_0   (i_code_0),
    .i_code_1   (i_code_1),
    .i_code_2   (i_code_2),
    .i_code_3   (i_code_3),
    .i_ready    (i_ready),
    .o_sel_code (o_sel_code),
    .o_en       (o_en),
    .o_code     (o_code),
    .o_valid    (o_valid),
    .o_grant    (o_grant)
  );

  task automatic chk(input string nm, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Monitor: every grant pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (!i_rst && o_grant != 4'b0000) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL sb_unexpected: got grant %b want none", o_grant);
        end else begin
          e = exp_q.pop_front();
          chk("sb_grant", int'(o_grant), int'(e.grant));
          chk("sb_code", int'(o_code), int'(e.code));
          chk("sb_valid", int'(o_valid), 1);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_req = 4'b0000;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic wait_grant(input string nm, output logic [3:0] g);
    g = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_grant != 4'b0000) begin
        g = o_grant;
        return;
      end
    end
    nvec++;
    nerr++;
    $display("FAIL %s_timeout: got no grant want grant", nm);
  endtask

  initial begin
    logic [3:0] g;
    int tg[5];
    int cyc;
    int n;
    i_rst = 1'b1;
    i_req = 4'b0000;
    i_ready = 1'b1;
    i_code_0 = 8'h10;
    i_code_1 = 8'h11;
    i_code_2 = 8'h12;
    i_code_3 = 8'h13;

    // Reset state
    do_reset();
    chk("rst_en", int'(o_en), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_grant", int'(o_grant), 0);
    chk("rst_code", int'(o_code), 0);
    chk("rst_sel", int'(o_sel_code), 0);

    // Single request on channel 2
    i_code_2 = 8'hA5;
    i_req = 4'b0100;
    exp_q.push_back('{4'b0100, 8'hA5});
    @(negedge i_clk);
    chk("single_sel_en", int'(o_en), 1);
    chk("single_sel", int'(o_sel_code), 2);
    chk("single_sel_valid", int'(o_valid), 0);
    @(negedge i_clk);
    chk("single_valid", int'(o_valid), 1);
    chk("single_code", int'(o_code), 8'hA5);
    i_req = 4'b0000;
    @(negedge i_clk);
    chk("single_done_valid", int'(o_valid), 0);
    chk("single_done_grant", int'(o_grant), 0);

    // Fairness: all four requesting from reset
    do_reset();
    i_code_2 = 8'h12;
    i_req = 4'b1111;
    exp_q.push_back('{4'b0001, 8'h10});
    exp_q.push_back('{4'b0010, 8'h11});
    exp_q.push_back('{4'b0100, 8'h12});
    exp_q.push_back('{4'b1000, 8'h13});
    exp_q.push_back('{4'b0001, 8'h10});
    n = 0;
    cyc = 0;
    while (n < 5 && cyc < 40) begin
      @(negedge i_clk);
      cyc++;
      if (o_grant != 4'b0000) begin
        tg[n] = cyc;
        n++;
      end
    end
    i_req = 4'b0000;
    chk("fair_count", n, 5);
    for (int k = 1; k < 5; k++)
      if (k < n)
        chk("fair_spacing", tg[k] - tg[k-1], 2);
    repeat (3) @(negedge i_clk);

    // Backpressure on channel 1
    do_reset();
    i_code_1 = 8'h5A;
    i_ready = 1'b0;
    i_req = 4'b0010;
    exp_q.push_back('{4'b0010, 8'h5A});
    wait_grant("bp", g);
    i_req = 4'b0000;
    i_code_1 = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk("bp_valid", int'(o_valid), 1);
      chk("bp_code", int'(o_code), 8'h5A);
      chk("bp_grant", int'(o_grant), 0);
      chk("bp_en", int'(o_en), 0);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("bp_release", int'(o_valid), 0);

    // Pointer wrap: ptr=3 after reset, channel 0 beats channel 3
    do_reset();
    i_code_0 = 8'hC0;
    i_code_3 = 8'hC3;
    i_req = 4'b1001;
    exp_q.push_back('{4'b0001, 8'hC0});
    exp_q.push_back('{4'b1000, 8'hC3});
    wait_grant("wrap0", g);
    i_req = i_req & ~g;
    wait_grant("wrap3", g);
    i_req = i_req & ~g;
    repeat (2) @(negedge i_clk);

    // Mid-operation reset during SEL
    do_reset();
    i_code_0 = 8'h77;
    i_req = 4'b0001;
    @(negedge i_clk);
    chk("midrst_sel_en", int'(o_en), 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("midrst_en", int'(o_en), 0);
    chk("midrst_valid", int'(o_valid), 0);
    chk("midrst_grant", int'(o_grant), 0);
    chk("midrst_code", int'(o_code), 0);
    i_rst = 1'b0;
    exp_q.push_back('{4'b0001, 8'h77});
    wait_grant("midrst_rearb", g);
    i_req = 4'b0000;
    repeat (2) @(negedge i_clk);

    // Idle: no requests for 10 cycles
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      chk("idle_en", int'(o_en), 0);
      chk("idle_valid", int'(o_valid), 0);
      chk("idle_grant", int'(o_grant), 0);
    end

    chk("sb_empty", exp_q.size(), 0);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL global_timeout: got hang want finish");
      $fatal(1);
    end
  end

endmodule
